// File: rtl/osc_pkg.sv
// Shared oscillator-path types and default widths.
// Used by the phase accumulator and the downstream waveform tables.
package osc_pkg;

    typedef enum logic {STOP, RUN} nco_state_e;

    localparam int unsigned PHASE_WIDTH_DEF = 24;
    localparam int unsigned DEPTH_DEF       = 512;

endpackage

// File: rtl/phase_accumulator.sv
// NCO phase accumulator: adds the tuning word on each sample tick and drives the table address.
// Latency: tick or sync at cycle N shows on addr_o/valid_o/wrap_o at N+1.
// Backpressure: one tuning word may wait in RUN; tuning_ready_o is low until it is applied at a wrap, sync or stop.
module phase_accumulator
    import osc_pkg::*;
#(
    parameter int unsigned phase_width_p = PHASE_WIDTH_DEF,
    parameter int unsigned depth_p       = DEPTH_DEF
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         en_i,
    input  logic                         sync_i,
    input  logic                         sample_tick_i,
    input  logic [phase_width_p-1:0]     tuning_word_i,
    input  logic                         tuning_valid_i,
    output logic                         tuning_ready_o,
    output logic [$clog2(depth_p)-1:0]   addr_o,
    output logic                         valid_o,
    output logic                         wrap_o
);

    localparam int unsigned addr_width_lp = $clog2(depth_p);

    nco_state_e                 state_q, state_d;
    logic [phase_width_p-1:0]   phase_q;
    logic [phase_width_p-1:0]   ftw_q;
    logic [phase_width_p-1:0]   pend_word_q;
    logic                       pend_q;
    logic                       valid_q;
    logic                       wrap_q;

    logic [phase_width_p:0]     sum;
    logic                       carry;
    logic                       tick_run;
    logic                       leaving;
    logic                       accept;
    logic                       apply_pend;

    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP:    if (en_i)  state_d = RUN;
            RUN:     if (!en_i) state_d = STOP;
            default: state_d = STOP;
        endcase
    end

    assign sum        = {1'b0, phase_q} + {1'b0, ftw_q};
    assign carry      = sum[phase_width_p];
    assign tick_run   = (state_q == RUN) && sample_tick_i;
    assign leaving    = (state_q == RUN) && !en_i;
    assign accept     = tuning_valid_i && !pend_q;
    // Frequency changes land only at phase-continuous points.
    assign apply_pend = pend_q && (sync_i || (tick_run && carry) || leaving);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= STOP;
            phase_q     <= '0;
            ftw_q       <= '0;
            pend_word_q <= '0;
            pend_q      <= 1'b0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;

            if (sync_i) begin
                phase_q <= '0;
            end else if (tick_run) begin
                phase_q <= sum[phase_width_p-1:0];
                valid_q <= 1'b1;
                wrap_q  <= carry;
            end

            if (apply_pend) begin
                ftw_q  <= pend_word_q;
                pend_q <= 1'b0;
            end

            // accept implies no word is pending, so it never collides with apply_pend.
            if (accept) begin
                if ((state_q == STOP) || leaving) begin
                    ftw_q <= tuning_word_i;
                end else begin
                    pend_word_q <= tuning_word_i;
                    pend_q      <= 1'b1;
                end
            end
        end
    end

    assign addr_o         = phase_q[phase_width_p-1 -: addr_width_lp];
    assign valid_o        = valid_q;
    assign wrap_o         = wrap_q;
    assign tuning_ready_o = !pend_q;

endmodule
